// File: rtl/aes_dec_ctrl.sv
// Control wrapper for an iterative AES inverse-cipher core: key load and
// expansion wait, single-block-in-flight decrypt, result hold and timeout.
module aes_dec_ctrl #(
  parameter int KEY_WAIT = 12,
  parameter int TIMEOUT  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_kld,
  output logic [127:0] core_key,
  output logic         core_ld,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         key_loaded,
  output logic         busy,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  localparam logic [2:0] S_NOKEY = 3'd0;
  localparam logic [2:0] S_KEYLD = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam int KCW = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
  localparam int RCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_WAIT - 1);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(TIMEOUT - 1);

  logic [2:0]     state_q, state_d;
  logic [KCW-1:0] key_cnt_q, key_cnt_d;
  logic [RCW-1:0] run_cnt_q, run_cnt_d;
  logic           core_kld_q, core_kld_d;
  logic           core_ld_q, core_ld_d;
  logic           key_loaded_q, key_loaded_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;
  logic [15:0]    blk_cnt_q, blk_cnt_d;
  logic [127:0]   core_key_q, core_key_d;
  logic [127:0]   core_text_q, core_text_d;
  logic [127:0]   out_data_q, out_data_d;

  logic key_hs;
  logic blk_hs;

  // A pending key always wins over a block offered in the same cycle.
  assign key_ready = (state_q == S_NOKEY) || (state_q == S_READY);
  assign blk_ready = (state_q == S_READY) && !out_valid_q && !key_valid;
  assign key_hs    = key_valid && key_ready;
  assign blk_hs    = blk_valid && blk_ready;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    run_cnt_d    = run_cnt_q;
    core_kld_d   = 1'b0;
    core_ld_d    = 1'b0;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    blk_cnt_d    = blk_cnt_q;
    core_key_d   = core_key_q;
    core_text_d  = core_text_q;
    out_data_d   = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_NOKEY, S_READY: begin
        if (key_hs) begin
          core_key_d   = key_in;
          core_kld_d   = 1'b1;
          key_loaded_d = 1'b0;
          key_cnt_d    = '0;
          state_d      = S_KEYLD;
        end else if (blk_hs) begin
          core_text_d = blk_in;
          core_ld_d   = 1'b1;
          state_d     = S_LOAD;
        end
      end

      // The core_kld cycle is the first counted cycle of the expansion wait.
      S_KEYLD: begin
        if (key_cnt_q == KEY_LAST) begin
          key_cnt_d    = '0;
          key_loaded_d = 1'b1;
          state_d      = S_READY;
        end else begin
          key_cnt_d = key_cnt_q + KCW'(1);
        end
      end

      S_LOAD: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        if (core_done) begin
          out_data_d  = core_text_out;
          out_valid_d = 1'b1;
          blk_cnt_d   = blk_cnt_q + 16'd1;
          run_cnt_d   = '0;
          state_d     = S_READY;
        end else if (run_cnt_q == RUN_LAST) begin
          // Block abandoned: flag it and drop the result silently.
          err_d     = 1'b1;
          run_cnt_d = '0;
          state_d   = S_READY;
        end else begin
          run_cnt_d = run_cnt_q + RCW'(1);
        end
      end

      default: state_d = S_NOKEY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_NOKEY;
      key_cnt_q    <= '0;
      run_cnt_q    <= '0;
      core_kld_q   <= 1'b0;
      core_ld_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      run_cnt_q    <= run_cnt_d;
      core_kld_q   <= core_kld_d;
      core_ld_q    <= core_ld_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

  // NOTE: wide data registers carry no reset; they are qualified by the strobes above.
  always_ff @(posedge clk) begin
    core_key_q  <= core_key_d;
    core_text_q <= core_text_d;
    out_data_q  <= out_data_d;
  end

  assign core_kld     = core_kld_q;
  assign core_ld      = core_ld_q;
  assign core_key     = core_key_q;
  assign core_text_in = core_text_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign key_loaded   = key_loaded_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign err          = err_q;
  assign blk_cnt      = blk_cnt_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl with a behavioural core model and a
// scoreboard of expected plaintexts; inputs driven and outputs sampled on negedge.
module tb_aes_dec_ctrl;

  localparam int KEY_WAIT = 12;
  localparam int TIMEOUT  = 32;
  localparam int CORE_LAT = 5;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, key_ready;
  logic [127:0] key_in;
  logic         blk_valid, blk_ready;
  logic [127:0] blk_in;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         core_kld, core_ld;
  logic [127:0] core_key, core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         key_loaded, busy, err;
  logic [15:0]  blk_cnt;

  // Core model controls
  logic         core_hang = 1'b0;
  logic         spur_done = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_key, m_ct;
  int           m_cnt = 0;

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_key;
  logic [127:0] last_exp;

  always #5 clk = ~clk;

  aes_dec_ctrl #(.KEY_WAIT(KEY_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_in(blk_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_kld(core_kld), .core_key(core_key),
    .core_ld(core_ld), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out),
    .key_loaded(key_loaded), .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  // Known-answer core: FIPS-197 vector decrypts exactly, other blocks use a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
    if (k == KAT_KEY && c == KAT_CT) return KAT_PT;
    return c ^ {k[63:0], k[127:64]} ^ 128'h5a5aa5a5_3c3cc3c3_0ff0f00f_96696996;
  endfunction

  assign core_done = m_done | spur_done;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (core_kld) m_key <= core_key;
    if (core_ld) begin
      m_ct  <= core_text_in;
      m_cnt <= CORE_LAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !core_hang) begin
        m_done        <= 1'b1;
        core_text_out <= core_fn(m_key, m_ct);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    int kld;
    int ld_seen;
    key_valid = 1'b1;
    key_in    = k;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
    check("key_ready_seen", key_ready, 1);
    tick();
    key_valid = 1'b0;
    cur_key   = k;
    check("core_kld_pulse", core_kld, 1);
    check("core_key_value", core_key, k);
    check("key_loaded_cleared", key_loaded, 0);
    check("kld_ld_exclusive", core_ld, 0);
    n = 0; kld = 1; ld_seen = 0;
    while (!key_loaded && n < 100) begin
      tick();
      n++;
      if (core_kld) kld++;
      if (core_ld) ld_seen++;
    end
    check("key_wait_cycles", n, KEY_WAIT);
    check("kld_pulse_count", kld, 1);
    check("no_core_ld_in_keyld", ld_seen, 0);
  endtask

  task automatic send_block(input logic [127:0] ct, input bit expect_out);
    int n;
    blk_valid = 1'b1;
    blk_in    = ct;
    if (expect_out) exp_q.push_back(core_fn(cur_key, ct));
    n = 0;
    while (!blk_ready && n < 200) begin tick(); n++; end
    check("blk_ready_seen", blk_ready, 1);
    tick();
    blk_valid = 1'b0;
    check("core_ld_pulse", core_ld, 1);
    check("core_text_in_value", core_text_in, ct);
    check("busy_in_load", busy, 1);
    check("ld_kld_exclusive", core_kld, 0);
  endtask

  task automatic get_result(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    last_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_out_data"}, out_data, last_exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    check("out_valid_cleared", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; key_valid = 1'b0; blk_valid = 1'b0; out_ready = 1'b0;
    key_in = '0; blk_in = '0; cur_key = '0; last_exp = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_key_ready", key_ready, 1);
    check("rst_blk_ready", blk_ready, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_kld", core_kld, 0);
    check("rst_core_ld", core_ld, 0);
    check("rst_blk_cnt", blk_cnt, 0);

    // Block offered before any key: stalled until the key is loaded
    blk_valid = 1'b1;
    blk_in    = KAT_CT;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nokey_blk_ready", blk_ready, 0);
      check("nokey_core_ld", core_ld, 0);
    end
    load_key(KAT_KEY);
    send_block(KAT_CT, 1'b1);
    get_result("kat");
    check("kat_blk_cnt", blk_cnt, 1);
    check("kat_busy_done", busy, 0);
    drain();

    // Result held under back-pressure; second block waits for the drain
    send_block(128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1);
    get_result("hold");
    blk_valid = 1'b1;
    blk_in    = 128'h0badc0de_11112222_33334444_55556666;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, last_exp);
      check("hold_blk_ready", blk_ready, 0);
      check("hold_core_ld", core_ld, 0);
    end
    drain();
    send_block(128'h0badc0de_11112222_33334444_55556666, 1'b1);
    get_result("after_drain");
    check("after_drain_blk_cnt", blk_cnt, 3);
    drain();

    // Key and block together in READY: key first, block after KEYLD
    blk_valid = 1'b1;
    blk_in    = 128'hfeedface_a5a5a5a5_5a5a5a5a_12345678;
    key_valid = 1'b1;
    key_in    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    #1;
    check("both_blk_ready", blk_ready, 0);
    check("both_key_ready", key_ready, 1);
    load_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    send_block(128'hfeedface_a5a5a5a5_5a5a5a5a_12345678, 1'b1);
    get_result("key_prio");
    check("key_prio_blk_cnt", blk_cnt, 4);
    drain();

    // core_done outside RUN is ignored
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    check("spur_out_valid", out_valid, 0);
    check("spur_blk_cnt", blk_cnt, 4);
    check("spur_out_data", out_data, last_exp);

    // Core never finishes: timeout after TIMEOUT RUN cycles
    core_hang = 1'b1;
    send_block(128'h00000000_11111111_22222222_33333333, 1'b0);
    check("to_err_before", err, 0);
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    check("to_busy_cycles", n, TIMEOUT + 1);
    check("to_err_set", err, 1);
    check("to_ready_state", blk_ready, 1);
    check("to_out_valid", out_valid, 0);
    check("to_blk_cnt", blk_cnt, 4);
    core_hang = 1'b0;

    // err is sticky across a good block
    send_block(128'h44444444_55555555_66666666_77777777, 1'b1);
    get_result("sticky");
    check("sticky_err", err, 1);
    check("sticky_blk_cnt", blk_cnt, 5);
    drain();

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut.blk_cnt_q = 16'hffff;
    #1;
    release dut.blk_cnt_q;
    check("wrap_preset", blk_cnt, 16'hffff);
    send_block(128'h88888888_99999999_aaaaaaaa_bbbbbbbb, 1'b1);
    get_result("wrap");
    check("wrap_blk_cnt", blk_cnt, 0);
    drain();

    // Reset in the middle of RUN aborts the block
    send_block(128'hcccccccc_dddddddd_eeeeeeee_ffffffff, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("midrun_busy", busy, 0);
    check("midrun_err", err, 0);
    check("midrun_blk_cnt", blk_cnt, 0);
    check("midrun_key_loaded", key_loaded, 0);
    check("midrun_key_ready", key_ready, 1);
    rst = 1'b1;
    repeat (8) tick();
    check("midrun_no_capture", out_valid, 0);
    check("midrun_cnt_stays", blk_cnt, 0);

    // Reset in the middle of KEYLD, then a full restart from NOKEY
    key_valid = 1'b1;
    key_in    = 128'h11223344_55667788_99aabbcc_ddeeff00;
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midkey_key_loaded", key_loaded, 0);
    check("midkey_key_ready", key_ready, 1);
    check("midkey_blk_ready", blk_ready, 0);
    load_key(KAT_KEY);
    send_block(KAT_CT, 1'b1);
    get_result("restart");
    check("restart_blk_cnt", blk_cnt, 1);
    drain();

    check("sb_empty_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
